// File: rtl/heap_array_allocator.sv
// Shared heap-array allocator: round-robin arbitrated alloc/free with a LIFO freed stack
// and a high-water counter. Define HEAP_ALLOC_DOUBLE_FREE_CHECK_EN to reject double frees.
module heap_array_allocator #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 200,
    parameter int NRequesters        = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NRequesters-1:0]                    req_valid,
    input  logic [NRequesters-1:0]                    req_free,
    input  logic [NRequesters*MemoryElementWidth-1:0] req_array,
    output logic [NRequesters-1:0]                    req_ready,
    output logic [NRequesters-1:0]                    rsp_valid,
    output logic [MemoryElementWidth-1:0]             rsp_array,
    output logic                                      rsp_error,
    output logic                                      size_clear_valid,
    output logic [MemoryElementWidth-1:0]             size_clear_array,
    output logic [$clog2(NArrays+1)-1:0]              allocs,
    output logic [$clog2(NArrays+1)-1:0]              free_top
);
    localparam int W    = MemoryElementWidth;
    localparam int CntW = $clog2(NArrays + 1);
    localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int RrW  = (NRequesters > 1) ? $clog2(NRequesters) : 1;

    logic [W-1:0]           freed_q [NArrays];
    logic [RrW-1:0]         rr_q, rr_d;
    logic [CntW-1:0]        allocs_q, allocs_d, free_top_q, free_top_d;
    logic [NRequesters-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]           rsp_array_q, rsp_array_d;
    logic                   rsp_error_q, rsp_error_d;
    logic                   sc_valid_q, sc_valid_d;
    logic [W-1:0]           sc_array_q, sc_array_d;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
    logic [NArrays-1:0]     in_use_q, in_use_d;
`endif

    logic [NRequesters-1:0] grant;
    logic                   found;
    logic [RrW-1:0]         gidx;
    int                     cand;
    logic                   op_free;
    logic [W-1:0]           op_handle;
    logic [W-1:0]           alloc_handle;
    logic                   alloc_ok, free_bad, push_en;
    logic [IdxW-1:0]        pop_idx, push_idx;

    // Round-robin search starting at rr_q; the first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        for (int k = 0; k < NRequesters; k++) begin
            cand = (int'(rr_q) + k) % NRequesters;
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = RrW'(cand);
            end
        end
    end

    assign req_ready = grant;
    assign op_free   = req_free[gidx];
    assign op_handle = req_array[gidx*W +: W];
    assign pop_idx   = IdxW'(free_top_q - CntW'(1));
    assign push_idx  = IdxW'(free_top_q);

    always_comb begin
        rr_d         = rr_q;
        allocs_d     = allocs_q;
        free_top_d   = free_top_q;
        rsp_valid_d  = '0;
        rsp_array_d  = '0;
        rsp_error_d  = 1'b0;
        sc_valid_d   = 1'b0;
        sc_array_d   = '0;
        alloc_handle = '0;
        alloc_ok     = 1'b0;
        free_bad     = 1'b0;
        push_en      = 1'b0;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
        in_use_d     = in_use_q;
`endif
        if (found) begin
            rr_d        = (int'(gidx) == NRequesters - 1) ? '0 : gidx + RrW'(1);
            rsp_valid_d = grant;
            if (!op_free) begin
                // Recycled handles take priority over fresh ones.
                if (free_top_q != '0) begin
                    alloc_handle = freed_q[pop_idx];
                    free_top_d   = free_top_q - CntW'(1);
                    alloc_ok     = 1'b1;
                end else if (allocs_q < CntW'(NArrays)) begin
                    alloc_handle = W'(allocs_q);
                    allocs_d     = allocs_q + CntW'(1);
                    alloc_ok     = 1'b1;
                end
                rsp_error_d = !alloc_ok;
                if (alloc_ok) begin
                    rsp_array_d = alloc_handle;
                    sc_valid_d  = 1'b1;
                    sc_array_d  = alloc_handle;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
                    in_use_d[alloc_handle[IdxW-1:0]] = 1'b1;
`endif
                end
            end else begin
                rsp_array_d = op_handle;
                free_bad    = (int'(op_handle) >= int'(allocs_q)) ||
                              (free_top_q == CntW'(NArrays));
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
                free_bad    = free_bad || !in_use_q[op_handle[IdxW-1:0]];
`endif
                rsp_error_d = free_bad;
                if (!free_bad) begin
                    push_en    = 1'b1;
                    free_top_d = free_top_q + CntW'(1);
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
                    in_use_d[op_handle[IdxW-1:0]] = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q        <= '0;
            allocs_q    <= '0;
            free_top_q  <= '0;
            rsp_valid_q <= '0;
            rsp_array_q <= '0;
            rsp_error_q <= 1'b0;
            sc_valid_q  <= 1'b0;
            sc_array_q  <= '0;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
            in_use_q    <= '0;
`endif
        end else begin
            rr_q        <= rr_d;
            allocs_q    <= allocs_d;
            free_top_q  <= free_top_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_array_q <= rsp_array_d;
            rsp_error_q <= rsp_error_d;
            sc_valid_q  <= sc_valid_d;
            sc_array_q  <= sc_array_d;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
            in_use_q    <= in_use_d;
`endif
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clock) begin
        if (push_en) begin
            freed_q[push_idx] <= op_handle;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_array        = rsp_array_q;
    assign rsp_error        = rsp_error_q;
    assign size_clear_valid = sc_valid_q;
    assign size_clear_array = sc_array_q;
    assign allocs           = allocs_q;
    assign free_top         = free_top_q;

endmodule

// File: tb/tb_heap_array_allocator.sv
// Scoreboard bench for heap_array_allocator with a 4-handle heap and two clients.
`timescale 1ns/1ps
module tb_heap_array_allocator;
    localparam int W  = 12;
    localparam int NA = 4;
    localparam int NR = 2;
    localparam int CW = $clog2(NA + 1);

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_free, req_ready, rsp_valid;
    logic [NR*W-1:0] req_array;
    logic [W-1:0]    rsp_array, size_clear_array;
    logic            rsp_error, size_clear_valid;
    logic [CW-1:0]   allocs, free_top;

    heap_array_allocator #(.MemoryElementWidth(W), .NArrays(NA), .NRequesters(NR)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_free(req_free), .req_array(req_array),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_array(rsp_array),
        .rsp_error(rsp_error), .size_clear_valid(size_clear_valid),
        .size_clear_array(size_clear_array), .allocs(allocs), .free_top(free_top)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NR-1:0] onehot;
        logic          err;
        logic [W-1:0]  arr;
        logic          sc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   m_allocs;
    int   m_rr;
    int   m_stack[$];
    bit   m_inuse[NA];

    task automatic clear_model();
        m_allocs = 0;
        m_rr     = 0;
        m_stack.delete();
        for (int i = 0; i < NA; i++) m_inuse[i] = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset     = 1'b1;
        clear_model();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one cycle of requests; the reference model predicts the winner and its response.
    task automatic step(input logic [1:0] v, input logic [1:0] f, input int a0, input int a1);
        exp_t e;
        int   g, h, a;
        bit   err;
        req_valid = v;
        req_free  = f;
        req_array = {12'(a1), 12'(a0)};
        if (v != 2'b00 && !reset) begin
            g   = v[m_rr] ? m_rr : 1 - m_rr;
            a   = g ? a1 : a0;
            err = 1'b0;
            h   = 0;
            if (!f[g]) begin
                if (m_stack.size() > 0) h = m_stack.pop_back();
                else if (m_allocs < NA) begin h = m_allocs; m_allocs++; end
                else err = 1'b1;
                if (!err) m_inuse[h] = 1'b1;
            end else begin
                h = a;
                if (a >= m_allocs || m_stack.size() == NA) err = 1'b1;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
                if (!err && !m_inuse[a]) err = 1'b1;
`endif
                if (!err) begin m_stack.push_back(a); m_inuse[a] = 1'b0; end
            end
            e.onehot = 2'(1 << g);
            e.err    = err;
            e.arr    = 12'(h);
            e.sc     = !f[g] && !err;
            sb.push_back(e);
            m_rr = (g + 1) % NR;
        end
        @(negedge clock);
    endtask

    // Response monitor: one expected entry per accepted request, otherwise silence.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (rsp_valid !== e.onehot) begin bad++; $display("FAIL rsp_valid got=%b want=%b", rsp_valid, e.onehot); end
                total++;
                if (rsp_error !== e.err) begin bad++; $display("FAIL rsp_error got=%b want=%b", rsp_error, e.err); end
                total++;
                if (rsp_array !== e.arr) begin bad++; $display("FAIL rsp_array got=%0d want=%0d", rsp_array, e.arr); end
                total++;
                if (size_clear_valid !== e.sc) begin bad++; $display("FAIL size_clear_valid got=%b want=%b", size_clear_valid, e.sc); end
                if (e.sc) begin
                    total++;
                    if (size_clear_array !== e.arr) begin bad++; $display("FAIL size_clear_array got=%0d want=%0d", size_clear_array, e.arr); end
                end
            end else begin
                total++;
                if (rsp_valid !== 2'b00) begin bad++; $display("FAIL idle_rsp_valid got=%b want=00", rsp_valid); end
                total++;
                if (size_clear_valid !== 1'b0) begin bad++; $display("FAIL idle_size_clear got=%b want=0", size_clear_valid); end
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        total++;
        if (rsp_error !== 1'b0 || rsp_array !== '0 || size_clear_array !== '0) begin
            bad++; $display("FAIL reset_rsp got=%b/%0d/%0d want=0/0/0", rsp_error, rsp_array, size_clear_array);
        end
        total++;
        if (allocs !== '0 || free_top !== '0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", allocs, free_top); end
        req_valid = 2'b01; req_free = 2'b00; req_array = '0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_req_ready got=%b want=01", req_ready); end
        @(negedge clock);
        total++;
        if (allocs !== '0) begin bad++; $display("FAIL reset_no_accept got=%0d want=0", allocs); end
        req_valid = '0;
        clear_model();
        reset = 1'b0;
    endtask

    task automatic test_alloc();
        repeat (3) step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
        total++;
        if (allocs !== 3'd3) begin bad++; $display("FAIL alloc_count got=%0d want=3", allocs); end
    endtask

    task automatic test_free_realloc();
        step(2'b01, 2'b01, 1, 0);
        total++;
        if (free_top !== 3'd1) begin bad++; $display("FAIL free_top_after_free got=%0d want=1", free_top); end
        step(2'b01, 2'b00, 0, 0);
        total++;
        if (free_top !== 3'd0 || allocs !== 3'd3) begin bad++; $display("FAIL realloc_counters got=%0d/%0d want=0/3", free_top, allocs); end
        step(2'b00, 2'b00, 0, 0);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = 2'b11; req_free = 2'b00;
            #1;
            total++;
            if (req_ready !== ((i % 2) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_grant_%0d got=%b want=%b", i, req_ready, (i % 2) ? 2'b10 : 2'b01);
            end
            step(2'b11, 2'b00, 0, 0);
        end
        step(2'b00, 2'b00, 0, 0);
        total++;
        if (allocs !== 3'd4) begin bad++; $display("FAIL rr_allocs got=%0d want=4", allocs); end
    endtask

    task automatic test_exhaustion();
        do_reset();
        repeat (5) step(2'b10, 2'b00, 0, 0);
        total++;
        if (allocs !== 3'd4) begin bad++; $display("FAIL exh_allocs got=%0d want=4", allocs); end
        step(2'b10, 2'b10, 0, 7);
        step(2'b10, 2'b10, 0, 4);
        total++;
        if (free_top !== 3'd0) begin bad++; $display("FAIL exh_bad_free got=%0d want=0", free_top); end
        step(2'b10, 2'b10, 0, 3);
        total++;
        if (free_top !== 3'd1) begin bad++; $display("FAIL exh_good_free got=%0d want=1", free_top); end
        step(2'b10, 2'b10, 0, 0);
        step(2'b10, 2'b10, 0, 1);
        step(2'b10, 2'b10, 0, 2);
        step(2'b10, 2'b10, 0, 3);
        total++;
        if (free_top !== 3'd4) begin bad++; $display("FAIL exh_stack_full got=%0d want=4", free_top); end
        step(2'b10, 2'b00, 0, 0);
        total++;
        if (free_top !== 3'd3) begin bad++; $display("FAIL exh_lifo_pop got=%0d want=3", free_top); end
        step(2'b00, 2'b00, 0, 0);
    endtask

    task automatic test_double_free();
        int want;
`ifdef HEAP_ALLOC_DOUBLE_FREE_CHECK_EN
        want = 1;
`else
        want = 2;
`endif
        do_reset();
        repeat (3) step(2'b01, 2'b00, 0, 0);
        step(2'b01, 2'b01, 2, 0);
        step(2'b01, 2'b01, 2, 0);
        total++;
        if (free_top !== 3'(want)) begin bad++; $display("FAIL double_free got=%0d want=%0d", free_top, want); end
        step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(2'b01, 2'b00, 0, 0);
        step(2'b11, 2'b10, 0, 0);
        step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
        total++;
        if (free_top !== 3'd0 || allocs !== 3'd1) begin bad++; $display("FAIL b2b_counters got=%0d/%0d want=0/1", free_top, allocs); end
    endtask

    task automatic test_reset_mid();
        step(2'b01, 2'b00, 0, 0);
        req_valid = 2'b01; req_free = 2'b00; req_array = '0;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (rsp_valid !== 2'b00) begin bad++; $display("FAIL mid_reset_rsp got=%b want=00", rsp_valid); end
        total++;
        if (allocs !== '0 || free_top !== '0) begin bad++; $display("FAIL mid_reset_counters got=%0d/%0d want=0/0", allocs, free_top); end
        @(negedge clock);
        req_valid = '0;
        clear_model();
        reset = 1'b0;
        step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_free  = '0;
        req_array = '0;
        clear_model();
        test_reset();
        test_alloc();
        test_free_realloc();
        test_round_robin();
        test_exhaustion();
        test_double_free();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heap_array_allocator.md
# heap_array_allocator

Shared allocator for the fixed-size heap arrays used by generated programs. It owns the freed-array stack, the high-water allocation counter and the array-size reset. Up to `NRequesters` clients request array allocations and frees through a round-robin arbiter. The block sits beside the heap memory and replaces per-program inline allocation logic.

## Interface
- `MemoryElementWidth`, 12, width of an array handle and of memory elements
- `NArrays`, 200, maximum number of arrays; handles are 0..NArrays-1
- `NRequesters`, 2, number of requesting clients
- `clock` input 1, single clock; all logic is on the rising edge
- `reset` input 1, asynchronous, active-high reset
- `req_valid` input NRequesters, per-client request
- `req_free` input NRequesters, per-client operation: 1 = free, 0 = allocate
- `req_array` input NRequesters*MemoryElementWidth, handle to free; client i uses slice i
- `req_ready` output NRequesters, one-hot grant; the request is accepted on the cycle it is high
- `rsp_valid` output NRequesters, one-hot; pulses one cycle after acceptance, to the accepted client
- `rsp_array` output MemoryElementWidth, allocated handle; echoes the handle on a free
- `rsp_error` output 1, qualifies `rsp_valid`; the operation failed with no state change
- `size_clear_valid` output 1, pulse telling the heap to zero `arraySizes[size_clear_array]`
- `size_clear_array` output MemoryElementWidth, handle whose size is cleared
- `allocs` output $clog2(NArrays+1), high-water count of handles ever issued
- `free_top` output $clog2(NArrays+1), depth of the freed stack

## Operation
- Storage:
  - `freed[NArrays]` stack of handles.
  - `free_top` pointer.
  - `allocs` counter.
  - Round-robin pointer `rr`.
- Arbitration:
  - Each cycle, grant the first requester with `req_valid` high, searching from `rr` upward with wrap-around.
  - At most one grant per cycle.
  - `req_ready[i]` is combinational from `req_valid` and `rr`.
  - After a grant to i, `rr` becomes (i+1) mod NRequesters.
  - With no requests, `rr` does not change.
- Allocate:
  - If `free_top` > 0: decrement `free_top` and return `freed[free_top-1]` (LIFO).
  - Else if `allocs` < NArrays: return `allocs` and increment `allocs`.
  - Else: `rsp_error`=1, `rsp_array`=0, no state change.
  - On success, pulse `size_clear_valid` with the handle, in the same cycle as `rsp_valid`.
- Free:
  - If the handle ≥ `allocs`, or `free_top` = NArrays: `rsp_error`=1, no push.
  - Otherwise write `freed[free_top]` = handle and increment `free_top`.
  - Free never pulses `size_clear_valid`.
- Response registers:
  - One response register set; it is overwritten every cycle.
  - `rsp_valid` is zero on cycles with no acceptance.
- Counter widths: `allocs` and `free_top` saturate logically at NArrays via the checks above and never wrap.

## Timing
- Throughput: one accepted operation per cycle, sustained.
- Latency: `rsp_valid` is asserted exactly one cycle after `req_ready` and `req_valid` are both high.
- A free accepted in cycle N is visible to an allocate accepted in cycle N+1: that allocate returns the freed handle.
- Simultaneous alloc and free from different clients: only the arbitration winner proceeds; the other holds `req_valid` and is granted next.
- Clients must hold `req_valid`, `req_free` and `req_array` stable until granted.
- Reset values (asynchronous):
  - `rsp_valid`=0, `rsp_error`=0, `rsp_array`=0
  - `size_clear_valid`=0, `size_clear_array`=0
  - `allocs`=0, `free_top`=0, `rr`=0
  - `req_ready` reflects `req_valid` combinationally, but nothing is accepted while `reset` is high.
- Reset mid-operation: a pending response is dropped and the stack contents become don't-care.

## Configuration
- `HEAP_ALLOC_DOUBLE_FREE_CHECK_EN`
- Defined:
  - Maintain an NArrays-bit in-use bitmap, set on allocate and cleared on free.
  - Freeing a handle that is not in use returns `rsp_error`=1 with no push.
- Undefined:
  - No bitmap; only the range and stack-full checks apply.
  - A double free pushes a duplicate handle.

## Test plan
- Reset, client 0 allocates three times → handles 0, 1, 2; `allocs`=3; `size_clear_valid` pulses with 0, 1, 2, each one cycle after its grant.
- Free 1, then allocate → returns 1; `free_top` goes 1 then 0; `allocs` stays 3.
- Both clients request every cycle for 6 cycles → grants alternate 0, 1, 0, 1, 0, 1; `rsp_valid` follows one cycle later to the matching client.
- NArrays=4: allocate 5 times → fifth response has `rsp_error`=1, `rsp_array`=0; free 7 → `rsp_error`=1.
- Double free of handle 2 → with `HEAP_ALLOC_DOUBLE_FREE_CHECK_EN`, the second free errors and `free_top`=1; without it, `free_top`=2.
- Assert `reset` in the cycle after a grant → `rsp_valid` stays 0; `allocs` and `free_top` read 0.
